mole_scheduler: RTL and testbench

Upstream stage of the scoring block. Picks a pseudo-random hole for each mole and times how long the mole stays visible. It drives mole_pos and the one-cycle mole_change strobe consumed by the scorer, and takes the scorer's guess_correct back as feedback. Hits shorten later mole windows, and misses accumulate toward game over.

---
 rtl/mole_scheduler.sv | 165 ++++++++++++++++
 tb/tb_mole_scheduler.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// mole_scheduler
// Upstream stage of the whack-a-mole scoring block. Chooses a pseudo-random
// hole for each mole, times the visible window and the hidden gap, shortens
// the window after every hit and counts missed windows toward game over.
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   start          level; leaves IDLE while high
//   guess_correct  scorer feedback; only its rising edge in SHOW is a hit
//   mole_pos       current hole index 0..7
//   mole_change    one-cycle pulse on the edge that loads a new mole_pos
//   mole_visible   high while a mole is up
//   miss_pulse     one-cycle pulse when a visible window times out
//   misses         saturating miss count
//   game_over      high in OVER
//   period_cur     current visible window in ticks
//
// state | meaning
// IDLE  | waiting for start, nothing visible
// SHOW  | mole visible, window timer running
// GAP   | mole hidden between windows, gap timer running
// OVER  | miss limit reached, frozen until rst
module mole_scheduler #(
  parameter int unsigned TICK_DIV    = 1000000,
  parameter int unsigned BASE_PERIOD = 100,
  parameter int unsigned MIN_PERIOD  = 30,
  parameter int unsigned STEP        = 5,
  parameter int unsigned GAP_TICKS   = 20,
  parameter int unsigned MAX_MISSES  = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       guess_correct,
  output logic [2:0] mole_pos,
  output logic       mole_change,
  output logic       mole_visible,
  output logic       miss_pulse,
  output logic [3:0] misses,
  output logic       game_over,
  output logic [7:0] period_cur
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHOW, GAP, OVER} state_t;

  state_t        state;
  logic [7:0]    lfsr;
  logic [PW-1:0] prescaler;
  logic [7:0]    tick_cnt;
  logic          gc_prev;

  logic          lfsr_fb;
  logic [2:0]    candidate;
  logic [2:0]    next_pos;
  logic          hit;
  logic          tick;
  logic          show_done;
  logic          gap_done;
  logic [3:0]    misses_inc;
  logic [7:0]    period_dec;

  always_comb begin
    lfsr_fb    = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    candidate  = lfsr[2:0];
    // 3-bit add wraps 7 to 0, so a new mole never lands on the previous hole
    next_pos   = (candidate == mole_pos) ? candidate + 3'd1 : candidate;
    hit        = guess_correct & ~gc_prev;
    tick       = (prescaler == PW'(TICK_DIV - 1));
    show_done  = tick && (tick_cnt == period_cur - 8'd1);
    gap_done   = tick && (tick_cnt == 8'(GAP_TICKS - 1));
    misses_inc = (misses == 4'd15) ? misses : misses + 4'd1;
    // compare before subtracting so the window cannot wrap below the floor
    if ({8'd0, period_cur} >= 16'(MIN_PERIOD + STEP))
      period_dec = period_cur - 8'(STEP);
    else
      period_dec = 8'(MIN_PERIOD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mole_pos     <= 3'd0;
      mole_change  <= 1'b0;
      mole_visible <= 1'b0;
      miss_pulse   <= 1'b0;
      misses       <= 4'd0;
      game_over    <= 1'b0;
      period_cur   <= 8'(BASE_PERIOD);
      lfsr         <= 8'hA5;
      prescaler    <= '0;
      tick_cnt     <= 8'd0;
      gc_prev      <= 1'b0;
    end else begin
      lfsr        <= {lfsr[6:0], lfsr_fb};
      gc_prev     <= guess_correct;
      mole_change <= 1'b0;
      miss_pulse  <= 1'b0;

      if (tick) begin
        prescaler <= '0;
        tick_cnt  <= tick_cnt + 8'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end

      case (state)
        IDLE: begin
          prescaler <= '0;
          tick_cnt  <= 8'd0;
          if (start) begin
            state        <= SHOW;
            mole_pos     <= next_pos;
            mole_change  <= 1'b1;
            mole_visible <= 1'b1;
          end
        end

        SHOW: begin
          // a hit in the last cycle of the window takes priority over expiry
          if (hit) begin
            state        <= GAP;
            prescaler    <= '0;
            tick_cnt     <= 8'd0;
            mole_visible <= 1'b0;
            period_cur   <= period_dec;
          end else if (show_done) begin
            prescaler    <= '0;
            tick_cnt     <= 8'd0;
            mole_visible <= 1'b0;
            miss_pulse   <= 1'b1;
            misses       <= misses_inc;
            if (misses_inc == 4'(MAX_MISSES)) begin
              state     <= OVER;
              game_over <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end

        GAP: begin
          if (gap_done) begin
            state        <= SHOW;
            prescaler    <= '0;
            tick_cnt     <= 8'd0;
            mole_pos     <= next_pos;
            mole_change  <= 1'b1;
            mole_visible <= 1'b1;
          end
        end

        OVER: begin
          prescaler <= '0;
          tick_cnt  <= 8'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
module tb_mole_scheduler;

  localparam int TD   = 4;
  localparam int BASE = 10;
  localparam int MINP = 6;
  localparam int STP  = 2;
  localparam int GAPT = 3;
  localparam int MAXM = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       gc = 1'b0;
  logic [2:0] mole_pos;
  logic       mole_change;
  logic       mole_visible;
  logic       miss_pulse;
  logic [3:0] misses;
  logic       game_over;
  logic [7:0] period_cur;

  int n_checks = 0;
  int n_errors = 0;

  mole_scheduler #(
    .TICK_DIV(TD), .BASE_PERIOD(BASE), .MIN_PERIOD(MINP),
    .STEP(STP), .GAP_TICKS(GAPT), .MAX_MISSES(MAXM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .guess_correct(gc),
    .mole_pos(mole_pos), .mole_change(mole_change), .mole_visible(mole_visible),
    .miss_pulse(miss_pulse), .misses(misses), .game_over(game_over),
    .period_cur(period_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase plus a cycles-remaining count for the current interval
  int m_phase;   // 0 idle, 1 show, 2 gap, 3 over
  int m_left;
  int m_pos, m_chg, m_vis, m_miss, m_misses, m_over, m_period;
  int m_lfsr, m_gcp;
  int prev_pos = 0;
  int prev_chg = 0;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v << 1) | fb) & 8'hFF;
  endfunction

  function automatic int pick(input int lf, input int cur);
    int c;
    c = lf & 7;
    return (c == cur) ? ((c + 1) % 8) : c;
  endfunction

  task automatic model_step();
    int hit;
    hit = (gc && !m_gcp) ? 1 : 0;
    if (rst) begin
      m_phase = 0; m_left = 0; m_pos = 0; m_chg = 0; m_vis = 0; m_miss = 0;
      m_misses = 0; m_over = 0; m_period = BASE; m_lfsr = 8'hA5; m_gcp = 0;
    end else begin
      m_chg = 0;
      m_miss = 0;
      case (m_phase)
        0: if (start) begin
          m_pos = pick(m_lfsr, m_pos); m_chg = 1; m_vis = 1;
          m_phase = 1; m_left = m_period * TD;
        end
        1: begin
          if (hit) begin
            m_vis = 0;
            m_period = (m_period - STP < MINP) ? MINP : m_period - STP;
            m_phase = 2; m_left = GAPT * TD;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_vis = 0; m_miss = 1;
              m_misses = (m_misses == 15) ? 15 : m_misses + 1;
              if (m_misses == MAXM) begin
                m_phase = 3; m_over = 1;
              end else begin
                m_phase = 2; m_left = GAPT * TD;
              end
            end
          end
        end
        2: begin
          m_left--;
          if (m_left == 0) begin
            m_pos = pick(m_lfsr, m_pos); m_chg = 1; m_vis = 1;
            m_phase = 1; m_left = m_period * TD;
          end
        end
        default: ;
      endcase
      m_lfsr = lfsr_next(m_lfsr);
      m_gcp = gc ? 1 : 0;
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("mole_pos", mole_pos, m_pos);
    chk("mole_change", mole_change, m_chg);
    chk("mole_visible", mole_visible, m_vis);
    chk("miss_pulse", miss_pulse, m_miss);
    chk("misses", misses, m_misses);
    chk("game_over", game_over, m_over);
    chk("period_cur", period_cur, m_period);
    if (mole_change) begin
      chk("change_back_to_back", prev_chg, 0);
      chk("pos_differs_from_previous", (mole_pos != 3'(prev_pos)) ? 1 : 0, 1);
    end
    prev_pos = mole_pos;
    prev_chg = mole_change;
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; gc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (mole_visible == lvl && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (n >= 400) chk("level_wait_timeout", n, 0);
  endtask

  int n;
  int exp_per[3] = '{8, 6, 6};
  int changes;
  int cyc;

  initial begin
    tick_n(2);
    rst = 1'b0;
    chk("reset_pos", mole_pos, 0);
    chk("reset_period", period_cur, BASE);
    chk("reset_visible", mole_visible, 0);

    // 1: timeout, miss, gap, new mole
    start_game();
    chk("t1_change", mole_change, 1);
    chk("t1_first_pos", mole_pos, 5);
    count_level(1'b1, n);
    chk("t1_show_len", n, 40);
    chk("t1_miss_pulse", miss_pulse, 1);
    chk("t1_misses", misses, 1);
    count_level(1'b0, n);
    chk("t1_gap_len", n, 12);
    chk("t1_change2", mole_change, 1);
    chk("t1_pos_changed", (mole_pos != 3'd5) ? 1 : 0, 1);

    // 2: hit 5 cycles into SHOW, level held across GAP into next SHOW
    tick_n(5);
    gc = 1'b1;
    @(negedge clk);
    chk("t2_vis_after_hit", mole_visible, 0);
    chk("t2_period", period_cur, 8);
    chk("t2_misses", misses, 1);
    chk("t2_no_miss_pulse", miss_pulse, 0);
    tick_n(19);
    gc = 1'b0;
    chk("t2_next_show_visible", mole_visible, 1);
    tick_n(3);
    chk("t2_period_hold", period_cur, 8);

    // 3: three hits, window floor
    do_reset();
    start_game();
    for (int i = 0; i < 3; i++) begin
      tick_n(2);
      gc = 1'b1;
      @(negedge clk);
      gc = 1'b0;
      chk("t3_period", period_cur, exp_per[i]);
      count_level(1'b0, n);
      chk("t3_gap_len", n, 12);
    end
    count_level(1'b1, n);
    chk("t3_floor_window", n, 24);

    // 4: three timeouts end the game
    do_reset();
    start_game();
    cyc = 0;
    while (!game_over && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk("t4_game_over", game_over, 1);
    chk("t4_misses", misses, 3);
    chk("t4_visible", mole_visible, 0);
    start = 1'b1;
    tick_n(2);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      gc = ~gc;
      @(negedge clk);
    end
    gc = 1'b0;
    tick_n(4);
    chk("t4_still_over", game_over, 1);
    chk("t4_still_hidden", mole_visible, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_over", game_over, 0);
    chk("t4_rst_misses", misses, 0);
    chk("t4_rst_period", period_cur, BASE);
    chk("t4_rst_pos", mole_pos, 0);
    rst = 1'b0;

    // 5: rising edge in the final window cycle counts as a hit
    do_reset();
    start_game();
    tick_n(39);
    gc = 1'b1;
    @(negedge clk);
    gc = 1'b0;
    chk("t5_hidden", mole_visible, 0);
    chk("t5_no_miss_pulse", miss_pulse, 0);
    chk("t5_misses", misses, 0);
    chk("t5_period", period_cur, 8);

    // 6: reset mid-SHOW and mid-GAP, then many moles
    do_reset();
    start_game();
    tick_n(10);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_show_rst_vis", mole_visible, 0);
    rst = 1'b0;
    start_game();
    chk("t6_lfsr_restart_pos", mole_pos, 5);
    count_level(1'b1, n);
    tick_n(5);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_gap_rst_misses", misses, 0);
    rst = 1'b0;
    start_game();
    chk("t6_lfsr_restart_pos2", mole_pos, 5);
    changes = 1;
    cyc = 0;
    while (changes < 1000 && cyc < 40000) begin
      gc = ~gc;
      @(negedge clk);
      cyc++;
      if (mole_change) changes++;
    end
    gc = 1'b0;
    chk("t6_mole_count", changes, 1000);

    tick_n(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
